// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared instruction format definitions for the lab CPU front end
package instruction_fetch_pkg;

    localparam int FETCH_ADDR_WIDTH = 16;
    localparam int FETCH_INSN_WIDTH = 28;
    localparam int OPCODE_MSB       = 27;
    localparam int OPCODE_LSB       = 24;
    localparam int OPERAND_WIDTH    = 24;

    function automatic logic [OPCODE_MSB-OPCODE_LSB:0] insn_opcode(
        input logic [FETCH_INSN_WIDTH-1:0] insn
    );
        return insn[OPCODE_MSB:OPCODE_LSB];
    endfunction

    function automatic logic [OPERAND_WIDTH-1:0] insn_operand(
        input logic [FETCH_INSN_WIDTH-1:0] insn
    );
        return insn[OPERAND_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/instruction_fetch_queue.sv
// rtl/instruction_fetch_queue.sv - 2-entry {pc, insn} FIFO with push/pop/flush
module fetch_queue
    import instruction_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = FETCH_ADDR_WIDTH,
    parameter int INSN_WIDTH = FETCH_INSN_WIDTH
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] push_pc,
    input  logic [INSN_WIDTH-1:0] push_insn,
    output logic [1:0]            count,
    output logic [ADDR_WIDTH-1:0] head_pc,
    output logic [INSN_WIDTH-1:0] head_insn
);

    logic [ADDR_WIDTH-1:0] pc_mem   [2];
    logic [INSN_WIDTH-1:0] insn_mem [2];
    logic                  rd_ptr;
    logic                  wr_ptr;

    // Storage is never cleared; a flush only rewinds the pointers and count.
    always_ff @(posedge Clock) begin
        if (push && !flush && !Reset) begin
            pc_mem[wr_ptr]   <= push_pc;
            insn_mem[wr_ptr] <= push_insn;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset || flush) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head_pc   = pc_mem[rd_ptr];
    assign head_insn = insn_mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC, ROM address and redirect handling in front of the fetch queue
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int                  ADDR_WIDTH = FETCH_ADDR_WIDTH,
    parameter int                  INSN_WIDTH = FETCH_INSN_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    output logic [ADDR_WIDTH-1:0] oAddress,
    input  logic [INSN_WIDTH-1:0] iInstruction,
    output logic [INSN_WIDTH-1:0] oInstruction,
    output logic [ADDR_WIDTH-1:0] oPC,
    output logic                  oValid,
    input  logic                  iReady,
    input  logic                  iRedirect,
    input  logic [ADDR_WIDTH-1:0] iRedirectAddr
);

    logic [ADDR_WIDTH-1:0] pc;
    logic [1:0]            count;
    logic                  pop;
    logic                  push;

    assign oValid = (count != 2'd0);
    assign pop    = oValid && iReady;
    // A pop frees a slot in the same cycle, so a full queue can still accept.
    assign push   = !iRedirect && ((count < 2'd2) || pop);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc <= RESET_ADDR;
        end else if (iRedirect) begin
            pc <= iRedirectAddr;
        end else if (push) begin
            pc <= pc + 1'b1;
        end
    end

    assign oAddress = pc;

    fetch_queue #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INSN_WIDTH (INSN_WIDTH)
    ) u_queue (
        .Clock     (Clock),
        .Reset     (Reset),
        .push      (push),
        .pop       (pop),
        .flush     (iRedirect),
        .push_pc   (pc),
        .push_insn (iInstruction),
        .count     (count),
        .head_pc   (oPC),
        .head_insn (oInstruction)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed plus random bench for instruction_fetch against a queue model
module tb_instruction_fetch;

    localparam int AW = 16;
    localparam int IW = 28;
    localparam logic [AW-1:0] RST_A = 16'h0000;

    logic          Clock = 1'b0;
    logic          Reset;
    logic [AW-1:0] oAddress;
    logic [IW-1:0] iInstruction;
    logic [IW-1:0] oInstruction;
    logic [AW-1:0] oPC;
    logic          oValid;
    logic          iReady;
    logic          iRedirect;
    logic [AW-1:0] iRedirectAddr;

    int errors = 0;
    int checks = 0;

    logic [AW-1:0] mq[$];
    logic [AW-1:0] mpc;

    instruction_fetch #(
        .ADDR_WIDTH (AW),
        .INSN_WIDTH (IW),
        .RESET_ADDR (RST_A)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .oAddress      (oAddress),
        .iInstruction  (iInstruction),
        .oInstruction  (oInstruction),
        .oPC           (oPC),
        .oValid        (oValid),
        .iReady        (iReady),
        .iRedirect     (iRedirect),
        .iRedirectAddr (iRedirectAddr)
    );

    always #5 Clock = ~Clock;

    function automatic logic [IW-1:0] rom(input logic [AW-1:0] a);
        return {a[3:0] ^ 4'h9, a[7:0] ^ 8'h3C, a};
    endfunction

    always_comb iInstruction = rom(oAddress);

    task automatic check_outputs();
        logic          exp_valid;
        exp_valid = (mq.size() > 0);
        checks++;
        assert (oValid === exp_valid) else begin
            errors++;
            $error("FAIL valid: got %b want %b", oValid, exp_valid);
        end
        checks++;
        assert (oAddress === mpc) else begin
            errors++;
            $error("FAIL address: got %h want %h", oAddress, mpc);
        end
        if (exp_valid) begin
            checks++;
            assert (oPC === mq[0]) else begin
                errors++;
                $error("FAIL pc: got %h want %h", oPC, mq[0]);
            end
            checks++;
            assert (oInstruction === rom(mq[0])) else begin
                errors++;
                $error("FAIL insn: got %h want %h", oInstruction, rom(mq[0]));
            end
        end
    endtask

    // One clock: drive inputs, check current outputs, then advance the model across the edge.
    task automatic cycle(input logic rst, input logic redir, input logic rdy,
                         input logic [AW-1:0] tgt);
        @(negedge Clock);
        Reset         = rst;
        iRedirect     = redir;
        iReady        = rdy;
        iRedirectAddr = tgt;
        check_outputs();
        @(posedge Clock);
        if (rst) begin
            mq.delete();
            mpc = RST_A;
        end else if (redir) begin
            mq.delete();
            mpc = tgt;
        end else begin
            if (mq.size() > 0 && rdy) void'(mq.pop_front());
            if (mq.size() < 2) begin
                mq.push_back(mpc);
                mpc = mpc + 16'd1;
            end
        end
    endtask

    initial begin
        int n;
        Reset = 1'b1;
        iRedirect = 1'b0;
        iReady = 1'b0;
        iRedirectAddr = '0;
        mpc = RST_A;

        // Reset, then streaming
        cycle(1, 0, 1, 0);
        cycle(1, 0, 1, 0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 1, 0);

        // Stall until full, then release
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);

        // Loop back from oPC=11 to 8
        cycle(1, 0, 1, 0);
        n = 0;
        while (!(mq.size() > 0 && mq[0] == 16'd11) && n < 40) begin
            cycle(0, 0, 1, 0);
            n++;
        end
        checks++;
        assert (n < 40) else begin
            errors++;
            $error("FAIL reach_pc11: got %0d cycles want <40", n);
        end
        cycle(0, 1, 1, 16'd8);
        for (int i = 0; i < 6; i++) cycle(0, 0, 1, 0);

        // Redirect with full queue and simultaneous pop
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
        cycle(0, 1, 1, 16'h0040);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);

        // PC wrap
        cycle(0, 1, 1, 16'hFFFD);
        for (int i = 0; i < 7; i++) cycle(0, 0, 1, 0);

        // Back-to-back redirects
        cycle(0, 1, 1, 16'h0100);
        cycle(0, 1, 1, 16'h0200);
        cycle(0, 1, 0, 16'h0300);
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0);

        // Reset beats a redirect mid-stream
        cycle(1, 1, 1, 16'h1234);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 3) != 0),
                  AW'($urandom));
        end
        cycle(0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch front end for the lab CPU. It is the reading side of the combinational program ROM: it drives the ROM address, captures the returned 28-bit instruction, and buffers it in a 2-entry queue. It presents the instruction to decode with a valid/ready handshake and accepts branch/jump redirects from execute. It sits between the ROM and the decode/execute stage and owns the program counter.

## Interface
- ADDR_WIDTH, 16, ROM address / PC width
- INSN_WIDTH, 28, instruction width (4-bit opcode + 24-bit operand field)
- RESET_ADDR, 0, PC value after reset
- Clock  in  1  single clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high
- oAddress  out  ADDR_WIDTH  ROM address, equals PC register
- iInstruction  in  INSN_WIDTH  ROM data, combinational response to oAddress in same cycle
- oInstruction  out  INSN_WIDTH  head-of-queue instruction
- oPC  out  ADDR_WIDTH  address oInstruction was fetched from
- oValid  out  1  queue non-empty
- iReady  in  1  decode accepts head this cycle
- iRedirect  in  1  branch/jump taken, flush and refetch
- iRedirectAddr  in  ADDR_WIDTH  redirect target (e.g. JMP/BLE 8-bit target zero-extended by execute)

## Operation
- State: PC register, 2-entry queue of {pc, insn}, 2-bit count (0..2), 1-bit read pointer, 1-bit write pointer.
- pop = oValid & iReady.
- push = !iRedirect & (count < 2 | pop).
- On push: enqueue {PC, iInstruction}; PC <= PC + 1, modulo 2^ADDR_WIDTH (16'hFFFF wraps to 0).
- No push: PC holds and the ROM is re-read the next cycle; the ROM is combinational, so re-reading has no side effect.
- Count update: count <= count + push - pop.
- Redirect (highest priority after Reset): count <= 0, both pointers <= 0, PC <= iRedirectAddr. Any simultaneous pop is discarded; decode must treat a head consumed in the redirect cycle as already executed by execute's own rules. No push in the redirect cycle.
- Reset: PC <= RESET_ADDR, count <= 0, pointers <= 0. Reset overrides iRedirect, iReady and push.
- Queue contents are not cleared on flush; only count/pointers. oInstruction/oPC are don't-care while oValid=0, but must be driven from the storage (no X on output mux select).
- Reset values of outputs: oValid=0, oAddress=RESET_ADDR. oInstruction/oPC are undefined.
- The block does not decode opcodes; all control flow arrives via iRedirect.

## Timing
- Fetch latency: the instruction at address A is available on oInstruction with oValid=1 on the cycle after the edge where PC=A was pushed.
- After Reset deasserts: first edge pushes RESET_ADDR; oValid=1 from the following cycle.
- After a redirect at edge r: oValid=0 during cycle r+1; edge r+1 pushes the target; the target is at the head with oValid=1 from cycle r+2. Redirect penalty = 1 bubble.
- Full queue (count=2) with iReady=0: no push, PC frozen, oAddress stable, head stable.
- Full with pop: simultaneous push and pop, count stays 2.
- Steady state with iReady=1: one instruction per cycle, oPC increments by 1 each cycle.
- Back-to-back redirects: each flushes; only the last target is fetched.

## Structure
- Opcode field position [27:24], operand field width (24) and INSN_WIDTH belong in the shared definitions header alongside the existing opcode defines. No new opcodes.
- One sub-module: fetch_queue, a 2-entry synchronous FIFO with push/pop/flush, count, head outputs and the same Clock/Reset. instruction_fetch holds the PC and push/redirect logic.

## Test plan
- Reset, iReady=1, ROM model returns {4'h0, addr}: oValid=0 in first cycle, then oPC = 0,1,2,3… one per cycle, instruction matches address.
- iReady=0 for 5 cycles from steady state: count reaches 2, oAddress frozen at head+2, oPC holds; release iReady → oPC resumes sequentially, no gap or duplicate.
- iRedirect with target 8 at oPC=11 (BLE loop back): oValid=0 next cycle, then oPC=8,9,10…
- iRedirect and iReady=1 with a full queue in the same cycle: both queued entries discarded, first valid oPC = target.
- PC=16'hFFFF with continuous fetch: next oPC = 0.
- Reset asserted mid-stream while oValid=1 and iRedirect=1: next cycle oValid=0 and oAddress=RESET_ADDR; redirect target ignored.
